serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial 8-bit adder datapath stage; sits directly upstream of full_adder.
//  - Latches two operands.
//  - Feeds one bit pair plus a registered carry into a single full_adder per clock.
//  - Collects sum bits; reports the result with a done pulse.
//  - Low-area alternative to the ripple adder inside the ALU.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      synchronous reset, active-low
//  start     in   1      request; accepted only while busy=0
//  a         in   WIDTH  operand A, sampled on accepting edge
//  b         in   WIDTH  operand B, sampled on accepting edge
//  c_in      in   1      carry-in, sampled on accepting edge
//  busy      out  1      high from accept edge until DONE exits
//  done      out  1      one-cycle pulse: result valid
//  sum       out  WIDTH  registered result; holds until next done
//  c_out     out  1      registered carry-out of MSB
//  overflow  out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset: rst_n=0 at any edge -> state IDLE; busy, done, sum, c_out, overflow,
//    shift regs, bit counter and carry reg all 0.
//    Reset mid-operation discards the partial result; no done pulse.
//  - States: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
//  - IDLE, start=1: a_sh<=a, b_sh<=b, cy<=c_in, cnt<=0; go to SHIFT; busy=1.
//  - SHIFT, each edge: full_adder(a_sh[0], b_sh[0], cy) -> s, co.
//    - s shifts into res_sh MSB (res_sh shifts right).
//    - a_sh/b_sh shift right; cy<=co; cnt<=cnt+1.
//    - When cnt==WIDTH-1: capture cin_msb<=cy (pre-update value) and go to DONE.
//    - On that same edge load sum<=final res_sh, c_out<=co, overflow<=cy^co.
//  - DONE: done=1 for exactly one cycle; busy=1; next edge -> IDLE.
//  - Latency: done is high in the cycle after the WIDTH-th edge following the
//    accepting edge. Back-to-back accept is possible on the edge after DONE.
//  - start while busy=1 (SHIFT or DONE) is ignored; operands are not resampled.
//  - a/b/c_in changing during SHIFT have no effect.
//  - Arithmetic is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  SERIAL_SUB_EN defined:
//    - Extra input port sub (1 bit), sampled with start.
//    - sub=1: b_sh<=~b and cy<=1; c_in is ignored. Result = a-b; c_out=1 means no borrow.
//    - sub=0: behaviour is identical to the undefined case.
//  SERIAL_SUB_EN undefined: no sub port; addition only.
// STRUCTURE
//  - Shared include alu_defs.vh: state encodings ST_IDLE/ST_SHIFT/ST_DONE;
//    ALU_WIDTH=8 default.
//  - One sub-module: full_adder (a, b, c_in, sum, c_out), instantiated once.
//  - Counter width $clog2(WIDTH); FSM plus shift regs live in this module.
// TESTING
//  - 8'h0F + 8'h01, c_in=0 -> sum=8'h10, c_out=0, overflow=0;
//    done is seen 8 edges after accept, busy drops the edge after.
//  - 8'hFF + 8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0;
//    8'h7F + 8'h01 -> sum=8'h80, c_out=0, overflow=1.
//  - 8'hAA + 8'h55, c_in=1 -> sum=8'h00, c_out=1.
//    A second start with 8'h01+8'h01 pulsed during SHIFT is ignored.
//    Exactly one done pulse; sum holds 8'h00.
//  - Reset mid-op: start 8'h12+8'h34, rst_n=0 at 4th SHIFT edge ->
//    busy=0, sum=8'h00, no done.
//    Restart after reset gives sum=8'h46.
//  - Back-to-back: start held high -> ops accepted every WIDTH+2 edges;
//    each done pulse carries the correct sum.
//  - SERIAL_SUB_EN: sub=1, 8'h05 - 8'h07 -> sum=8'hFE, c_out=0;
//    8'h07 - 8'h05 -> sum=8'h02, c_out=1.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_ctrl_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder used once per clock by the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder per clock, LSB first, done pulse on completion.
// Optional subtract mode (extra port sub) is enabled by defining SERIAL_SUB_EN.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] b_load;
  logic             cy_load;

`ifdef SERIAL_SUB_EN
  // Subtract as a + ~b + 1; c_in is ignored in that mode.
  assign b_load  = sub ? ~b : b;
  assign cy_load = sub ? 1'b1 : c_in;
`else
  assign b_load  = b;
  assign cy_load = c_in;
`endif

  full_adder u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (cy_q),
    .sum   (fa_s),
    .c_out (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          cy_d    = cy_load;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cy_d     = fa_co;
        cnt_d    = cnt_q + CW'(1);
        // On the MSB step cy_q is the carry into the MSB.
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_sh_d;
          c_out_d = fa_co;
          ovf_d   = cy_q ^ fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    sum      = sum_q;
    c_out    = c_out_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, scoreboard queue and corner-case sequences.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, c_in, busy, done, c_out, overflow;
  logic [7:0] a, b, sum;
`ifdef SERIAL_SUB_EN
  logic       sub;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  res_t exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef SERIAL_SUB_EN
    .sub      (sub),
`endif
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic ci);
    logic [8:0] t;
    t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
    model.s  = t[7:0];
    model.co = t[8];
    model.ov = (x[7] == y[7]) && (t[7] != x[7]);
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done sum=%0h", sum);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_sum", 32'(sum), 32'(e.s));
        chk("sb_c_out", 32'(c_out), 32'(e.co));
        chk("sb_overflow", 32'(overflow), 32'(e.ov));
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic ci);
    a     = x;
    b     = y;
    c_in  = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) break;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int   n;
    int   d0;
    logic [7:0] ra, rb;
    logic rc;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[3] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{tbl[i].s, tbl[i].co, tbl[i].ov});
      start_op(tbl[i].a, tbl[i].b, tbl[i].ci);
      wait_done(n);
      chk("latency", 32'(n), 32'd8);
      @(posedge clk);
      #1;
      chk("busy_drop", 32'(busy), 32'd0);
      chk("done_single", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(tbl[i].s));
    end

    // Reset on the 4th SHIFT edge discards the operation.
    d0 = done_cnt;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_c_out", 32'(c_out), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back('{8'h46, 1'b0, 1'b0});
    start_op(8'h12, 8'h34, 1'b0);
    wait_done(n);
    chk("restart_latency", 32'(n), 32'd8);
    chk("restart_sum", 32'(sum), 32'h46);
    @(posedge clk);
    #1;

    // A start pulse during SHIFT must be ignored.
    d0 = done_cnt;
    exp_q.push_back('{8'h00, 1'b1, 1'b0});
    start_op(8'hAA, 8'h55, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    a     = 8'h01;
    b     = 8'h01;
    c_in  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    chk("ignore_latency", 32'(n), 32'd5);
    repeat (12) @(posedge clk);
    #1;
    chk("ignore_one_done", 32'(done_cnt - d0), 32'd1);
    chk("ignore_sum_hold", 32'(sum), 32'h00);
    chk("ignore_idle", 32'(busy), 32'd0);

    // Back-to-back with start held high; operands change during SHIFT.
    ra = 8'($urandom);
    rb = 8'($urandom);
    rc = 1'($urandom);
    a = ra; b = rb; c_in = rc; start = 1'b1;
    exp_q.push_back(model(ra, rb, rc));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("b2b_accept", 32'(busy), 32'd1);
      if (k < 3) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        a = ra; b = rb; c_in = rc;
        exp_q.push_back(model(ra, rb, rc));
      end else begin
        start = 1'b0;
      end
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_idle_gap", 32'(busy), 32'd0);
    end

`ifdef SERIAL_SUB_EN
    sub = 1'b1;
    exp_q.push_back('{8'hFE, 1'b0, 1'b0});
    start_op(8'h05, 8'h07, 1'b0);
    wait_done(n);
    chk("sub_latency", 32'(n), 32'd8);
    @(posedge clk);
    #1;
    exp_q.push_back('{8'h02, 1'b1, 1'b0});
    start_op(8'h07, 8'h05, 1'b1);
    wait_done(n);
    chk("sub_sum", 32'(sum), 32'h02);
    @(posedge clk);
    #1;
    sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
